aes_cipher_core: RTL and testbench



---
 rtl/aes_cipher_core.sv | 209 ++++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// aes_cipher_core
//   AES-128 encryption datapath. Each clock performs one full round. The core
//   sits directly downstream of aes_key_expander: it requests the key schedule
//   with encrypt_en, selects round keys with key_sel, and reads round_key in
//   the same cycle that key_sel is presented.
//
//   State and key matrices are indexed [row][col]. Byte n of the FIPS-197
//   block maps to [n % 4][n / 4], so column 0 holds bytes 0..3.
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   asynchronous, active-high reset
//     start      in   encrypt request, accepted only while in_ready = 1
//     data_in    in   plaintext state, sampled on the accept edge
//     in_ready   out  high only in IDLE
//     encrypt_en out  key-schedule request to the expander (WAIT_KEY, RUN)
//     key_rdy    in   round keys valid, from the expander
//     key_sel    out  registered round-key index, 0..NUM_ROUNDS
//     round_key  in   round key selected by key_sel (combinational)
//     data_out   out  ciphertext, held until the next done
//     done       out  one-cycle pulse when data_out is updated
//     busy       out  high in WAIT_KEY and RUN
//
//   Build option
//     AES_KEY_STALL_EN : when defined, a RUN cycle with key_rdy = 0 freezes
//                        the state, round and key_sel. When undefined, RUN
//                        ignores key_rdy.
module aes_cipher_core #(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned KEY_SEL_W  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [3:0][3:0][7:0]       data_in,
   output logic                       in_ready,
   output logic                       encrypt_en,
   input  logic                       key_rdy,
   output logic [KEY_SEL_W-1:0]       key_sel,
   input  logic [3:0][3:0][7:0]       round_key,
   output logic [3:0][3:0][7:0]       data_out,
   output logic                       done,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_KEY = 2'd1,
      RUN      = 2'd2
   } fsm_e;

   localparam logic [KEY_SEL_W-1:0] RND_ONE  = {{(KEY_SEL_W-1){1'b0}}, 1'b1};
   localparam logic [KEY_SEL_W-1:0] LAST_RND = KEY_SEL_W'(NUM_ROUNDS);

   // FIPS-197 S-box. Entry 0 occupies the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   fsm_e                    fsm_q, fsm_d;
   logic [3:0][3:0][7:0]    st_q, st_d;
   logic [KEY_SEL_W-1:0]    round_q, round_d;
   logic [KEY_SEL_W-1:0]    key_sel_q, key_sel_d;
   logic [3:0][3:0][7:0]    data_out_q, data_out_d;
   logic                    done_q, done_d;

   logic [3:0][3:0][7:0]    sub_s, shf_s, mix_s, rnd_out;
   logic [7:0]              col_x;
   logic                    advance;

   // ---------------------------------------------------------------------
   // Round datapath: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey
   // ---------------------------------------------------------------------
   always_comb begin
      sub_s   = '0;
      shf_s   = '0;
      mix_s   = '0;
      col_x   = '0;
      rnd_out = '0;

      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            sub_s[r][c] = SBOX[st_q[r][c]];
         end
      end

      // Row r rotates left by r columns; 2-bit cast wraps the column index.
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            shf_s[r][c] = sub_s[r][2'(c + r)];
         end
      end

      // b[r] = a[r] ^ (a0^a1^a2^a3) ^ xtime(a[r] ^ a[r+1]) expands to the
      // {2,3,1,1} circulant row without separate multiply-by-3 terms.
      for (int unsigned c = 0; c < 4; c++) begin
         col_x = shf_s[0][c] ^ shf_s[1][c] ^ shf_s[2][c] ^ shf_s[3][c];
         for (int unsigned r = 0; r < 4; r++) begin
            mix_s[r][c] = shf_s[r][c] ^ col_x ^
                          xtime(shf_s[r][c] ^ shf_s[2'(r + 1)][c]);
         end
      end

      rnd_out = ((round_q == LAST_RND) ? shf_s : mix_s) ^ round_key;
   end

   // ---------------------------------------------------------------------
   // Control FSM: next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
`ifdef AES_KEY_STALL_EN
      advance = key_rdy;
`else
      advance = 1'b1;
`endif
   end

   always_comb begin
      fsm_d      = fsm_q;
      st_d       = st_q;
      round_d    = round_q;
      key_sel_d  = key_sel_q;
      data_out_d = data_out_q;
      done_d     = 1'b0;

      unique case (fsm_q)
         IDLE: begin
            key_sel_d = '0;
            if (start) begin
               st_d  = data_in;
               fsm_d = WAIT_KEY;
            end
         end
         WAIT_KEY: begin
            if (key_rdy) begin
               st_d      = st_q ^ round_key;
               key_sel_d = RND_ONE;
               round_d   = RND_ONE;
               fsm_d     = RUN;
            end
         end
         RUN: begin
            if (advance) begin
               st_d = rnd_out;
               if (round_q == LAST_RND) begin
                  data_out_d = rnd_out;
                  done_d     = 1'b1;
                  key_sel_d  = '0;
                  round_d    = '0;
                  fsm_d      = IDLE;
               end else begin
                  key_sel_d = key_sel_q + RND_ONE;
                  round_d   = round_q + RND_ONE;
               end
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q      <= IDLE;
         st_q       <= '0;
         round_q    <= '0;
         key_sel_q  <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         st_q       <= st_d;
         round_q    <= round_d;
         key_sel_q  <= key_sel_d;
         data_out_q <= data_out_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      in_ready   = (fsm_q == IDLE);
      busy       = (fsm_q != IDLE);
      encrypt_en = (fsm_q != IDLE);
      key_sel    = key_sel_q;
      data_out   = data_out_q;
      done       = done_q;
   end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core. The bench plays the key expander:
// round_key is a combinational lookup of key_sel into a schedule computed
// here. Known-answer FIPS-197 vectors are hex constants; the all-ones vector
// uses a byte-array reference encryptor whose S-box is derived from the
// GF(2^8) inverse and affine map.
module tb_aes_cipher_core;

   localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam int LAT = 11;   // edges from accept edge to the edge that raises done
`ifdef AES_KEY_STALL_EN
   localparam int STALL_LAT = LAT + 3;
`else
   localparam int STALL_LAT = LAT;
`endif

   logic                 clk, reset, start, in_ready, encrypt_en, key_rdy, done, busy;
   logic [3:0]           key_sel;
   logic [3:0][3:0][7:0] data_in, round_key, data_out;
   logic [3:0][3:0][7:0] rk_tab [11];
   logic [31:0]          kw [44];
   logic [7:0]           tsb [256];
   int                   checks, failures;

   aes_cipher_core #(.NUM_ROUNDS(10), .KEY_SEL_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .data_in    (data_in),
      .in_ready   (in_ready),
      .encrypt_en (encrypt_en),
      .key_rdy    (key_rdy),
      .key_sel    (key_sel),
      .round_key  (round_key),
      .data_out   (data_out),
      .done       (done),
      .busy       (busy)
   );

   assign round_key = (key_sel <= 4'd10) ? rk_tab[key_sel] : '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] xt(input logic [7:0] b);
      return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         tsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic set_key(input logic [127:0] key);
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) kw[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = kw[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {tsb[tmp[31:24]], tsb[tmp[23:16]], tsb[tmp[15:8]], tsb[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = xt(rc);
         end
         kw[i] = kw[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
               rk_tab[r][j][c] = kw[4*r+c][31-8*j -: 8];
   endtask

   // Reference encryption with the schedule currently in kw.
   function automatic logic [127:0] ref_enc(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   acc, cf;
      logic [127:0] o;
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ kw[k/4][31-8*(k%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int k = 0; k < 16; k++) s[k] = tsb[s[k]];
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
               t[j+4*c] = s[j + 4*((c+j)%4)];
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) begin
               if (r < 10) begin
                  acc = 8'h00;
                  for (int i = 0; i < 4; i++) begin
                     cf = (i == j) ? 8'h02 : ((i == (j+1)%4) ? 8'h03 : 8'h01);
                     acc = acc ^ gmul(cf, t[i+4*c]);
                  end
                  s[j+4*c] = acc;
               end else begin
                  s[j+4*c] = t[j+4*c];
               end
            end
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ kw[4*r + k/4][31-8*(k%4) -: 8];
      end
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
      return o;
   endfunction

   function automatic logic [3:0][3:0][7:0] to_state(input logic [127:0] b);
      logic [3:0][3:0][7:0] st;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = b[127-8*(4*c+r) -: 8];
      return st;
   endfunction

   function automatic logic [127:0] from_state(input logic [3:0][3:0][7:0] st);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = st[r][c];
      return o;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Steps edges until done is seen (bounded). With stall_ks >= 0, key_rdy
   // is dropped for three edges once key_sel reaches stall_ks.
   task automatic wait_done(input int stall_ks, output int lat, output bit got);
      int drop;
      bit stalled;
      lat = 0; got = 1'b0; drop = 0; stalled = 1'b0;
      while (!got && lat < 100) begin
         if (stall_ks >= 0 && !stalled && key_sel === 4'(stall_ks)) begin
            key_rdy = 1'b0;
            stalled = 1'b1;
            drop    = 3;
         end
         @(posedge clk); #1;
         lat++;
         if (drop > 0) begin
            drop--;
            if (drop == 0) key_rdy = 1'b1;
         end
         if (done === 1'b1) got = 1'b1;
      end
   endtask

   // Called #1 after an edge with the DUT idle.
   task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input int exp_lat, input int stall_ks);
      int lat;
      bit got;
      set_key(key);
      data_in = to_state(pt);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      data_in = ~data_in;
      chk({tag, "_accepted"}, {126'd0, busy, in_ready}, 128'b10);
      wait_done(stall_ks, lat, got);
      chk({tag, "_done_seen"}, 128'(got), 128'd1);
      chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      chk({tag, "_data_out"}, from_state(data_out), exp_ct);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 128'(done), 128'd0);
      chk({tag, "_hold"}, from_state(data_out), exp_ct);
      chk({tag, "_idle"}, {122'd0, in_ready, busy, key_sel}, {122'd0, 1'b1, 1'b0, 4'd0});
   endtask

   initial begin
      int lat, n, m, bad, ndone, dout_err, ks_err;
      bit got;
      logic [127:0] exp_ff;

      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; key_rdy = 1'b1; data_in = '0;
      build_sbox();
      set_key(KEY_B);

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_in_ready",   128'(in_ready),   128'd1);
      chk("rst_encrypt_en", 128'(encrypt_en), 128'd0);
      chk("rst_key_sel",    128'(key_sel),    128'd0);
      chk("rst_data_out",   from_state(data_out), 128'd0);
      chk("rst_done",       128'(done),       128'd0);
      chk("rst_busy",       128'(busy),       128'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: FIPS-197 Appendix B with key_rdy high
      run_block("t1_fips_b", KEY_B, PT_B, CT_B, LAT, -1);

      // 2: key_rdy low for 20 cycles after start
      key_rdy = 1'b0;
      data_in = to_state(PT_B);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (!(busy === 1'b1 && encrypt_en === 1'b1 && key_sel === 4'd0 &&
               done === 1'b0 && in_ready === 1'b0)) bad++;
      end
      chk("t2_wait_key_hold", 128'(bad), 128'd0);
      key_rdy = 1'b1;
      wait_done(-1, lat, got);
      chk("t2_done_seen", 128'(got), 128'd1);
      chk("t2_latency_from_key_rdy", 128'(lat), 128'(LAT));
      chk("t2_data_out", from_state(data_out), CT_B);
      @(posedge clk); #1;

      // 3: start held high for 40 cycles
      data_in = to_state(PT_B);
      start   = 1'b1;
      ks_err = 0; ndone = 0; dout_err = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         m = (e - 1) % 12;
         if (key_sel !== 4'((m == 0 || m == 11) ? 0 : m)) ks_err++;
         if (done === 1'b1) begin
            ndone++;
            if (from_state(data_out) !== CT_B) dout_err++;
         end
      end
      start = 1'b0;
      chk("t3_blocks_done", 128'(ndone), 128'd3);
      chk("t3_key_sel_seq", 128'(ks_err), 128'd0);
      chk("t3_data_out", 128'(dout_err), 128'd0);
      wait_done(-1, lat, got);
      chk("t3_fourth_block_done", 128'(got), 128'd1);
      chk("t3_fourth_data_out", from_state(data_out), CT_B);
      @(posedge clk); #1;

      // 4: asynchronous reset at round 5
      data_in = to_state(PT_B);
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (key_sel !== 4'd5 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t4_reached_round5", 128'(key_sel), 128'd5);
      #2 reset = 1'b1;
      #1;
      chk("t4_rst_data_out", from_state(data_out), 128'd0);
      chk("t4_rst_key_sel", 128'(key_sel), 128'd0);
      chk("t4_rst_flags", {124'd0, in_ready, encrypt_en, busy, done}, {124'd0, 4'b1000});
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      run_block("t4_after_reset", KEY_B, PT_B, CT_B, LAT, -1);

      // 5: boundary key/data
      run_block("t5_zero", '0, '0, CT_ZERO, LAT, -1);
      set_key('1);
      exp_ff = ref_enc('1);
      run_block("t5_ones", '1, '1, exp_ff, LAT, -1);
      run_block("t5_fips_c", KEY_C, PT_C, CT_C, LAT, -1);

      // 6: key_rdy dropped for three cycles at round 4
      run_block("t6_key_stall", KEY_B, PT_B, CT_B, STALL_LAT, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
